// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
//   Sequential front-end for the combinational alu block. Commands are queued
//   in a small FIFO and presented one at a time on registered ALU inputs. One
//   cycle later the 2N-bit ALU result is captured and returned on a
//   valid/ready response port.
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake; cmd_op1, cmd_op2, cmd_operation
//   alu_operand1/2       registered operands to alu
//   alu_operation        registered operation code to alu
//   alu_result           2N-bit result from alu
//   rsp_valid/rsp_ready  response handshake; rsp_data, rsp_operation
//   count                FIFO occupancy
//
// FSM states
//   state   | meaning
//   S_IDLE  | no command in flight; waits for a queued command
//   S_DRIVE | alu inputs loaded; ALU settles, result captured at the edge
//   S_RESP  | response held until rsp_ready
module alu_cmd_issuer #(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [N-1:0]               cmd_op1,
  input  logic [N-1:0]               cmd_op2,
  input  logic [3:0]                 cmd_operation,
  output logic [N-1:0]               alu_operand1,
  output logic [N-1:0]               alu_operand2,
  output logic [3:0]                 alu_operation,
  input  logic [2*N-1:0]             alu_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [2*N-1:0]             rsp_data,
  output logic [3:0]                 rsp_operation,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int WW = 2*N + 4;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [N-1:0]    op1_q, op1_d;
  logic [N-1:0]    op2_q, op2_d;
  logic [3:0]      oper_q, oper_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [2*N-1:0]  rsp_data_q, rsp_data_d;
  logic [3:0]      rsp_oper_q, rsp_oper_d;

  logic            push;
  logic            pop;
  logic            load;
  logic [WW-1:0]   cmd_word;
  logic [WW-1:0]   load_word;

  // Ready comes from the registered count only, so a pop in the same cycle
  // never opens a slot in a full FIFO.
  assign cmd_ready = (count_q != FULL) & ~reset;
  assign push      = cmd_valid & cmd_ready;
  assign cmd_word  = {cmd_operation, cmd_op1, cmd_op2};

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_oper_d  = rsp_oper_q;
    pop         = 1'b0;
    load        = 1'b0;
    load_word   = mem_q[rd_ptr_q];

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          load    = 1'b1;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = alu_result;
        rsp_oper_d  = oper_q;
        pop         = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (count_q != '0) begin
            load    = 1'b1;
            state_d = S_DRIVE;
          end else if (push) begin
            // Empty FIFO: the command being written this cycle is the head,
            // so take it straight from the inputs. It is popped in S_DRIVE.
            load      = 1'b1;
            load_word = cmd_word;
            state_d   = S_DRIVE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op1_d    = op1_q;
    op2_d    = op2_q;
    oper_d   = oper_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (load) begin
      oper_d = load_word[WW-1 -: 4];
      op1_d  = load_word[2*N-1 -: N];
      op2_d  = load_word[N-1:0];
    end
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      oper_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_oper_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      oper_q      <= oper_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_oper_q  <= rsp_oper_d;
    end
  end

  // Storage needs no reset: entries are only read once count says they exist.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_word;
  end

  assign alu_operand1  = op1_q;
  assign alu_operand2  = op2_q;
  assign alu_operation = oper_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_operation = rsp_oper_q;
  assign count         = count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op1, cmd_op2, cmd_operation;
  logic [3:0] alu_operand1, alu_operand2, alu_operation;
  logic [7:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [3:0] rsp_operation;
  logic [2:0] count;

  int n_checks = 0;
  int n_err    = 0;
  int n_rsp    = 0;
  int cyc      = 0;
  int last_hs  = 0;
  bit have_last = 0;
  bit gap_en    = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  // Bench ALU: concatenation exposes the operand wiring independent of opcode.
  assign alu_result = {alu_operand1, alu_operand2};

  alu_cmd_issuer #(.N(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_operation(cmd_operation),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_operation(alu_operation), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_operation(rsp_operation),
    .count(count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    logic acc;
    acc = 1'b0;
    cmd_op1 = a; cmd_op2 = b; cmd_operation = op; cmd_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      acc = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    if (acc) exp_q.push_back({op, a, b});
    else check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input int target, input int budget);
    for (int k = 0; k < budget && n_rsp < target; k++) tick();
    check("rsp_count", n_rsp, target);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op1 = '0; cmd_op2 = '0; cmd_operation = '0;

    fork
      forever begin
        logic [11:0] e;
        @(negedge clk);
        cyc++;
        if (!gap_en) have_last = 0;
        if (!reset && rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            check("rsp_extra", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_data", rsp_data, e[7:0]);
            check("rsp_operation", rsp_operation, e[11:8]);
            if (gap_en && have_last) check("rsp_gap", cyc - last_hs, 2);
            last_hs = cyc;
            have_last = gap_en;
          end
          n_rsp++;
        end
      end
    join_none

    // Reset values
    tick(); tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_count", count, 0);
    check("rst_op1", alu_operand1, 0);
    check("rst_op2", alu_operand2, 0);
    check("rst_operation", alu_operation, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_operation", rsp_operation, 0);
    reset = 1'b0;
    tick();
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_count", count, 0);

    // Single command: push at t
    rsp_ready = 1'b1;
    push_cmd(4'hA, 4'h3, 4'h2);
    check("single_count_t", count, 1);
    tick();  // t+1
    check("single_op1", alu_operand1, 4'hA);
    check("single_op2", alu_operand2, 4'h3);
    check("single_operation", alu_operation, 4'h2);
    check("single_valid_t1", rsp_valid, 0);
    tick();  // t+2
    check("single_valid_t2", rsp_valid, 1);
    check("single_data_t2", rsp_data, 8'hA3);
    check("single_oper_t2", rsp_operation, 4'h2);
    tick();  // t+3
    check("single_valid_t3", rsp_valid, 0);
    check("single_rsp_count", n_rsp, 1);
    tick();

    // Fill with backpressure
    rsp_ready = 1'b0;
    push_cmd(4'h1, 4'hF, 4'h1);
    push_cmd(4'h2, 4'hF, 4'h2);
    push_cmd(4'h3, 4'hF, 4'h3);
    // cmd3 pushed at the same edge the DRIVE state popped cmd1
    check("pushpop_count", count, 2);
    check("fill_rsp_valid", rsp_valid, 1);
    check("fill_rsp_data", rsp_data, 8'h1F);
    push_cmd(4'h4, 4'hF, 4'h4);
    push_cmd(4'h5, 4'hF, 4'h5);
    check("full_count", count, 4);
    check("full_cmd_ready", cmd_ready, 0);

    // Next command stalls while full and the response is held
    cmd_op1 = 4'h6; cmd_op2 = 4'hF; cmd_operation = 4'h6; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_count", count, 4);
      check("stall_cmd_ready", cmd_ready, 0);
      check("hold_rsp_data", rsp_data, 8'h1F);
      check("hold_rsp_oper", rsp_operation, 4'h1);
    end

    // Drain in order while pushing six more (pointers wrap)
    gap_en = 1'b1;
    rsp_ready = 1'b1;
    push_cmd(4'h6, 4'hF, 4'h6);
    push_cmd(4'h7, 4'hE, 4'h7);
    push_cmd(4'h8, 4'hD, 4'h8);
    push_cmd(4'h9, 4'hC, 4'h9);
    push_cmd(4'hA, 4'hB, 4'hA);
    push_cmd(4'hB, 4'hA, 4'hB);
    wait_rsp(12, 60);
    gap_en = 1'b0;
    tick(); tick();
    check("drain_count", count, 0);
    check("drain_rsp_valid", rsp_valid, 0);
    check("drain_queue_empty", exp_q.size(), 0);

    // Reset in RESP with three queued commands
    rsp_ready = 1'b0;
    push_cmd(4'hC, 4'h1, 4'h3);
    push_cmd(4'hD, 4'h2, 4'h4);
    push_cmd(4'hE, 4'h3, 4'h5);
    push_cmd(4'hF, 4'h4, 4'h6);
    check("pre_rst_count", count, 3);
    check("pre_rst_rsp_valid", rsp_valid, 1);
    reset = 1'b1;
    tick();
    exp_q.delete();
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_count", count, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    reset = 1'b0;
    tick();
    check("midrst_op1", alu_operand1, 0);
    rsp_ready = 1'b1;
    push_cmd(4'h5, 4'hC, 4'h7);
    wait_rsp(13, 20);
    for (int i = 0; i < 6; i++) tick();
    check("final_rsp_count", n_rsp, 13);
    check("final_rsp_valid", rsp_valid, 0);
    check("final_count", count, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
